// File: rtl/sd_dat_tx.sv
// SD DAT-line block transmitter: pops 32-bit words from the transmit buffer and
// frames them with start bit, per-line CRC16 and end bit in 1-bit or 4-bit mode.
module sd_dat_tx #(
    parameter int unsigned BlockLenWidth = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     sd_clk_en_i,
    input  logic                     start_i,
    input  logic [BlockLenWidth-1:0] block_size_i,
    input  logic                     bus_width_4_i,
    input  logic [31:0]              front_data_i,
    input  logic                     empty_i,
    output logic                     pop_front_o,
    output logic [3:0]               dat_o,
    output logic [3:0]               dat_en_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     underrun_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_END
    } state_t;

    state_t                   state;
    logic                     bus4;
    logic [BlockLenWidth-3:0] word_cnt;
    logic [4:0]               bit_cnt;
    logic [3:0]               crc_cnt;
    logic [31:0]              shreg;
    logic [3:0][15:0]         crc;
    logic [3:0][15:0]         crc_upd;
    logic [3:0][15:0]         crc_shl;

    logic [31:0] stream;
    logic [31:0] src;
    logic [3:0]  unit;
    logic [3:0]  mask;
    logic [3:0]  crc_out;
    logic [4:0]  last_bit;
    logic        word_done;
    logic        need_load;
    logic        unused_size_bits;

    assign unused_size_bits = ^block_size_i[1:0];

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // Byte-reverse so the stream goes out from bit 31 downward: byte 0 first, MSB first.
    assign stream    = {front_data_i[7:0], front_data_i[15:8], front_data_i[23:16], front_data_i[31:24]};
    assign last_bit  = bus4 ? 5'd7 : 5'd31;
    assign word_done = (bit_cnt == last_bit);
    assign need_load = (state == ST_START) || ((state == ST_DATA) && word_done && (word_cnt != '0));
    assign src       = need_load ? stream : shreg;
    assign unit      = bus4 ? src[31:28] : {3'b111, src[31]};
    assign mask      = bus4 ? 4'hF : 4'h1;
    assign crc_out   = bus4 ? {crc[3][15], crc[2][15], crc[1][15], crc[0][15]} : {3'b111, crc[0][15]};

    always_comb begin
        crc_upd    = '0;
        crc_shl    = '0;
        crc_upd[0] = crc16_step(crc[0], unit[0]);
        crc_upd[1] = crc16_step(crc[1], unit[1]);
        crc_upd[2] = crc16_step(crc[2], unit[2]);
        crc_upd[3] = crc16_step(crc[3], unit[3]);
        crc_shl[0] = {crc[0][14:0], 1'b0};
        crc_shl[1] = {crc[1][14:0], 1'b0};
        crc_shl[2] = {crc[2][14:0], 1'b0};
        crc_shl[3] = {crc[3][14:0], 1'b0};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            bus4        <= 1'b0;
            word_cnt    <= '0;
            bit_cnt     <= '0;
            crc_cnt     <= '0;
            shreg       <= '0;
            crc         <= '0;
            pop_front_o <= 1'b0;
            dat_o       <= 4'hF;
            dat_en_o    <= 4'h0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            underrun_o  <= 1'b0;
        end else begin
            pop_front_o <= 1'b0;
            done_o      <= 1'b0;
            underrun_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i && (block_size_i[BlockLenWidth-1:2] != '0)) begin
                        word_cnt <= block_size_i[BlockLenWidth-1:2];
                        bus4     <= bus_width_4_i;
                        busy_o   <= 1'b1;
                        state    <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (sd_clk_en_i) begin
                        dat_o    <= bus4 ? 4'h0 : 4'hE;
                        dat_en_o <= mask;
                        crc      <= '0;
                        bit_cnt  <= '0;
                        crc_cnt  <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START, ST_DATA: begin
                    if (sd_clk_en_i) begin
                        if (need_load && empty_i) begin
                            underrun_o <= 1'b1;
                            dat_o      <= 4'hF;
                            dat_en_o   <= 4'h0;
                            busy_o     <= 1'b0;
                            state      <= ST_IDLE;
                        end else if ((state == ST_DATA) && word_done && (word_cnt == '0)) begin
                            dat_o   <= crc_out;
                            crc     <= crc_shl;
                            crc_cnt <= '0;
                            state   <= ST_CRC;
                        end else begin
                            dat_o <= unit;
                            shreg <= bus4 ? {src[27:0], 4'h0} : {src[30:0], 1'b0};
                            crc   <= bus4 ? crc_upd : {crc[3:1], crc_upd[0]};
                            if (need_load) begin
                                word_cnt    <= word_cnt - 1'b1;
                                pop_front_o <= 1'b1;
                                bit_cnt     <= '0;
                                state       <= ST_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                end
                ST_CRC: begin
                    if (sd_clk_en_i) begin
                        if (crc_cnt == 4'd15) begin
                            dat_o <= 4'hF;
                            state <= ST_END;
                        end else begin
                            dat_o   <= crc_out;
                            crc     <= crc_shl;
                            crc_cnt <= crc_cnt + 4'd1;
                        end
                    end
                end
                ST_END: begin
                    if (sd_clk_en_i) begin
                        dat_o    <= 4'hF;
                        dat_en_o <= 4'h0;
                        done_o   <= 1'b1;
                        busy_o   <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_dat_tx.sv
// Directed and randomized checks of sd_dat_tx framing, CRC, pops, underrun and reset.
module tb_sd_dat_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        start = 1'b0;
    logic        bus4 = 1'b0;
    logic        empty = 1'b1;
    logic [11:0] block_size = '0;
    logic [31:0] front = '0;
    logic        pop, busy, done, underrun;
    logic [3:0]  dat, dat_en;

    sd_dat_tx #(.BlockLenWidth(12)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sd_clk_en_i  (en),
        .start_i      (start),
        .block_size_i (block_size),
        .bus_width_4_i(bus4),
        .front_data_i (front),
        .empty_i      (empty),
        .pop_front_o  (pop),
        .dat_o        (dat),
        .dat_en_o     (dat_en),
        .busy_o       (busy),
        .done_o       (done),
        .underrun_o   (underrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] bufq[$];
    logic [31:0] sent[$];
    logic [7:0]  samp[$];
    int          pop_cnt = 0, done_cnt = 0, und_cnt = 0, done_idx = -1, und_idx = -1;
    logic        en_q = 1'b0;
    int unsigned gap_min = 3, gap_max = 3;
    int          gcnt = 0;
    logic [3:0]  nib_exp [8] = '{4'h7, 4'h8, 4'h5, 4'h6, 4'h3, 4'h4, 4'h1, 4'h2};

    always @(posedge clk) en_q <= en;

    always @(negedge clk) begin
        if (gcnt == 0) begin
            en   = 1'b1;
            gcnt = int'($urandom_range(gap_max, gap_min)) - 1;
        end else begin
            en   = 1'b0;
            gcnt = gcnt - 1;
        end
    end

    // Bit-time sampler and buffer model: one sample per enable, taken after the update edge.
    always @(negedge clk) begin
        if (en_q) samp.push_back({dat_en, dat});
        if (pop) begin
            pop_cnt++;
            if (bufq.size() > 0) void'(bufq.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_idx = samp.size() - 1;
        end
        if (underrun) begin
            und_cnt++;
            und_idx = samp.size() - 1;
        end
        empty = (bufq.size() == 0);
        front = empty ? 32'h0 : bufq[0];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    function automatic int find_start();
        for (int i = 0; i < samp.size(); i++)
            if (samp[i][7:4] != 4'h0) return i;
        return -1;
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_all();
        tick();
        samp.delete();
        sent.delete();
        bufq.delete();
        pop_cnt = 0; done_cnt = 0; und_cnt = 0; done_idx = -1; und_idx = -1;
    endtask

    task automatic push_word(input logic [31:0] w);
        bufq.push_back(w);
        sent.push_back(w);
    endtask

    task automatic do_start(input logic [11:0] size, input logic b4);
        tick();
        block_size = size;
        bus4       = b4;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int   d0, u0;
        logic ended;
        d0 = done_cnt; u0 = und_cnt; ended = 1'b0;
        for (int i = 0; i < 40000 && !ended; i++) begin
            tick();
            ended = (done_cnt != d0) || (und_cnt != u0);
        end
        check_eq({tag, "_ended"}, ended, 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [11:0] size, input logic b4);
        do_start(size, b4);
        wait_end(tag);
    endtask

    task automatic check_frame(input string tag, input logic b4);
        logic [15:0] c[4];
        logic [3:0]  mask, nib;
        logic [31:0] w;
        logic [7:0]  by;
        logic [7:0]  e[$];
        int          s, nmis;
        for (int l = 0; l < 4; l++) c[l] = 16'h0;
        mask = b4 ? 4'hF : 4'h1;
        e.push_back({mask, b4 ? 4'h0 : 4'hE});
        for (int wi = 0; wi < sent.size(); wi++) begin
            w = sent[wi];
            for (int b = 0; b < 4; b++) begin
                by = w[8*b +: 8];
                if (b4) begin
                    for (int h = 1; h >= 0; h--) begin
                        nib = by[4*h +: 4];
                        for (int l = 0; l < 4; l++) c[l] = crc_step(c[l], nib[l]);
                        e.push_back({mask, nib});
                    end
                end else begin
                    for (int k = 7; k >= 0; k--) begin
                        c[0] = crc_step(c[0], by[k]);
                        e.push_back({mask, 3'b111, by[k]});
                    end
                end
            end
        end
        for (int k = 15; k >= 0; k--)
            e.push_back(b4 ? {mask, c[3][k], c[2][k], c[1][k], c[0][k]} : {mask, 3'b111, c[0][k]});
        e.push_back({mask, 4'hF});
        e.push_back(8'h0F);
        s = find_start();
        nmis = 0;
        for (int i = 0; i < e.size(); i++)
            if (s < 0 || s + i >= samp.size() || samp[s+i] != e[i]) nmis++;
        check_eq({tag, "_frame_mismatches"}, nmis, 0);
    endtask

    initial begin
        int          s, hi_seen, nw;
        logic [15:0] crc_seen;

        // reset values
        repeat (3) tick();
        check_eq("rst_dat", dat, 4'hF);
        check_eq("rst_dat_en", dat_en, 4'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_pop", pop, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_underrun", underrun, 1'b0);
        rst = 1'b0;
        tick();

        // 4-bit, one word 0x12345678
        clear_all();
        push_word(32'h12345678);
        run_frame("w4", 12'd4, 1'b1);
        s = find_start();
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("w4_nib%0d", i), (s >= 0 && s + 1 + i < samp.size()) ? samp[s+1+i][3:0] : 4'hx, nib_exp[i]);
        check_frame("w4", 1'b1);
        check_eq("w4_pops", pop_cnt, 1);
        check_eq("w4_done_cnt", done_cnt, 1);
        check_eq("w4_done_latency", done_idx - s, 26);
        check_eq("w4_busy_after", busy, 1'b0);

        // 1-bit, 512 bytes of 0xFF
        clear_all();
        for (int i = 0; i < 128; i++) push_word(32'hFFFF_FFFF);
        run_frame("w1", 12'd512, 1'b0);
        check_frame("w1", 1'b0);
        s = find_start();
        crc_seen = 16'h0;
        for (int k = 0; k < 16; k++)
            if (s >= 0 && s + 4097 + k < samp.size()) crc_seen = {crc_seen[14:0], samp[s+4097+k][0]};
        check_eq("w1_crc", crc_seen, 16'h7FA1);
        hi_seen = 0;
        foreach (samp[i]) if (samp[i][7:5] != 3'b000) hi_seen = 1;
        check_eq("w1_hi_enables", hi_seen, 0);
        check_eq("w1_pops", pop_cnt, 128);
        check_eq("w1_done_cnt", done_cnt, 1);

        // underrun at the second word load
        clear_all();
        push_word(32'hA5A5_5A5A);
        run_frame("ur", 12'd8, 1'b1);
        s = find_start();
        check_eq("ur_underrun_cnt", und_cnt, 1);
        check_eq("ur_underrun_at", und_idx - s, 9);
        check_eq("ur_done_cnt", done_cnt, 0);
        check_eq("ur_pops", pop_cnt, 1);
        check_eq("ur_dat_en", dat_en, 4'h0);
        check_eq("ur_busy", busy, 1'b0);

        // reset mid-DATA, then a clean frame
        clear_all();
        for (int i = 0; i < 4; i++) push_word(32'hDEAD_0000 + i);
        do_start(12'd16, 1'b1);
        repeat (30) tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_dat", dat, 4'hF);
        check_eq("midrst_dat_en", dat_en, 4'h0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_pop", pop, 1'b0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check_eq("midrst_no_done", done_cnt, 0);
        check_eq("midrst_no_underrun", und_cnt, 0);
        clear_all();
        push_word(32'h0BAD_F00D);
        push_word(32'h1357_9BDF);
        run_frame("rec", 12'd8, 1'b1);
        check_frame("rec", 1'b1);

        // start while busy is ignored
        clear_all();
        push_word(32'hCAFE_BABE);
        push_word(32'h0123_4567);
        do_start(12'd8, 1'b1);
        repeat (10) tick();
        check_eq("busy_mid", busy, 1'b1);
        do_start(12'd4, 1'b0);
        check_eq("busy_after_restart", busy, 1'b1);
        wait_end("busy");
        check_frame("busy", 1'b1);
        check_eq("busy_pops", pop_cnt, 2);
        check_eq("busy_done_cnt", done_cnt, 1);

        // block size 3 gives zero words and is ignored
        clear_all();
        push_word(32'h1111_2222);
        do_start(12'd3, 1'b1);
        repeat (20) tick();
        check_eq("sz3_busy", busy, 1'b0);
        check_eq("sz3_pops", pop_cnt, 0);
        check_eq("sz3_no_frame", find_start(), -1);

        // random data, sizes, modes and enable spacing
        gap_min = 3;
        gap_max = 10;
        for (int it = 0; it < 4; it++) begin
            clear_all();
            nw = int'($urandom_range(8, 1));
            for (int i = 0; i < nw; i++) push_word($urandom());
            bus4 = 1'($urandom_range(1, 0));
            run_frame($sformatf("rnd%0d", it), 12'(nw * 4), bus4);
            check_frame($sformatf("rnd%0d", it), bus4);
            check_eq($sformatf("rnd%0d_pops", it), pop_cnt, nw);
            check_eq($sformatf("rnd%0d_done", it), done_cnt, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_dat_tx.md
# sd_dat_tx

SD data-line block transmitter for the host-to-card write path. It pops 32-bit words from the SRAM-backed transmit buffer and serializes them onto DAT[3:0]. Each block is framed with a start bit, per-line CRC16 and an end bit, in 1-bit or 4-bit bus mode. It sits between the buffer data port and the SD pad drivers, and is paced by an SD-clock enable from the clock divider.

## Interface
- `BlockLenWidth`, default 12: width of `block_size_i` in bytes.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `sd_clk_en_i` in 1: one-cycle pulse marking one SD bit-time, at the falling edge of the SD clock. Pulses are at least 3 `clk_i` cycles apart.
- `start_i` in 1: pulse to begin one block transfer.
- `block_size_i` in BlockLenWidth: block length in bytes. Bits [1:0] are ignored.
- `bus_width_4_i` in 1: selects the bus mode. 1 = 4-bit mode, 0 = 1-bit mode (DAT0 only).
- `front_data_i` in 32: buffer head word. Byte 0 is in bits [7:0].
- `empty_i` in 1: buffer empty.
- `pop_front_o` out 1: one-cycle pop request to the buffer.
- `dat_o` out 4: DAT line values.
- `dat_en_o` out 4: per-line output enables.
- `busy_o` out 1: a transfer is in progress.
- `done_o` out 1: one-cycle pulse when a block has completed.
- `underrun_o` out 1: one-cycle pulse when the buffer was empty at a word load.

## Operation
- FSM states: IDLE, ARMED, START, DATA, CRC, END. All transitions except IDLE→ARMED happen only on cycles with `sd_clk_en_i`=1.
- IDLE:
  - `start_i`=1 with `block_size_i[BlockLenWidth-1:2]`≠0 latches the word count and the bus mode, then moves to ARMED. `busy_o`=1 from the next cycle.
  - A word count of 0 is ignored.
  - `start_i` in any other state is ignored.
- ARMED→START: active lines drive 0 (start bit) and their enables are set.
  - Active lines are DAT[3:0] in 4-bit mode and DAT0 only in 1-bit mode.
  - DAT[3:1] stay undriven in 1-bit mode.
- START→DATA is the first word load; see the word-load rules below.
- DATA: each enable shifts out the next bit (1-bit mode) or nibble (4-bit mode).
  - Order: byte 0 first, then bytes 1, 2, 3. Each byte is sent MSB first.
  - In 4-bit mode the high nibble of a byte is sent first, with bit 7 on DAT3.
  - A word occupies 32 bit-times (1-bit mode) or 8 bit-times (4-bit mode).
- Word load: happens when the shift register is exhausted and more words remain, including the START→DATA transition.
  - If `empty_i`=0: `front_data_i` is copied into the shift register and `pop_front_o` pulses in the following cycle.
  - If `empty_i`=1: `underrun_o` pulses, the FSM aborts to IDLE, and all enables clear. No `done_o` pulse is produced.
- CRC16, polynomial x^16+x^12+x^5+1:
  - Each active line has its own CRC, initialised to 0 at START.
  - The CRC covers that line's data bits only.
  - After the last data bit-time the FSM enters CRC and sends 16 bits per line, MSB first.
- END: drives 1 on active lines for one bit-time.
  - The next enable returns the FSM to IDLE, clears all enables and drives `dat_o`=4'hF.
  - `done_o` pulses and `busy_o` drops in that same cycle.
- Counters:
  - Bit-in-word counter: 5 bits.
  - Word counter: BlockLenWidth-2 bits, counting down to 0.
  - CRC counter: 4 bits.
  - None of the counters wraps beyond its terminal value.

## Timing
- All outputs are registered. `dat_o` and `dat_en_o` change in the `clk_i` cycle after the `sd_clk_en_i` cycle that caused the transition.
- Reset values:
  - `dat_o`=4'hF, `dat_en_o`=0.
  - `pop_front_o`=0, `busy_o`=0, `done_o`=0, `underrun_o`=0.
  - FSM in IDLE; counters and CRCs cleared.
- Asserting `rst_i` mid-transfer immediately forces the reset values. No pop, done or underrun pulse is issued.
- `front_data_i` and `empty_i` are sampled only at word loads. The buffer's two-cycle post-pop latency is covered by the minimum enable spacing of 3 cycles and the word length of at least 8 bit-times.
- Frame length in bit-times: 1 (start) + 8·bytes/width + 16 (CRC) + 1 (end).
- `pop_front_o` never pulses more than once per word, and never after the last word.

## Test plan
- 4-bit mode, 4-byte block, word 0x12345678:
  - DAT nibbles after the start bit are 7,8,5,6,3,4,1,2.
  - 16 CRC nibbles follow, then the end bit.
  - Exactly one pop; `done_o` pulses once, 26 bit-times after START.
- 1-bit mode, 512 bytes of 0xFF:
  - DAT0 sends 4096 ones, then CRC 0x7FA1, then the end bit.
  - DAT[3:1] enables stay 0 and exactly 128 pops occur.
- 4-bit mode, 8 bytes, buffer holds only 1 word:
  - `underrun_o` pulses at the second word load.
  - FSM returns to IDLE and `dat_en_o`=0, with no `done_o` pulse.
- `rst_i` asserted mid-DATA:
  - Outputs go to reset values in the same cycle.
  - A later `start_i` produces a clean frame with CRC restarted from 0.
- `start_i` while busy and `start_i` with `block_size_i`=3: both are ignored, and `busy_o` and the pop count are unchanged.
- Random enable spacing of 3–10 cycles with random data and sizes: the frame matches the reference model bit-for-bit on every line.
